// File: rtl/normalizer_pkg.sv
// Shared configuration for the normalizer: default field widths and FSM state encodings.
package normalizer_pkg;

    localparam int unsigned EXP_SIZE_DEF    = 8;
    localparam int unsigned MANTIS_SIZE_DEF = 23;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/normalizer.sv
// Iterative post-add normalizer: left-shifts the mantissa one bit per cycle until the
// leading one reaches the MSB or the exponent bottoms out at zero (denormal).
module normalizer
    import normalizer_pkg::*;
#(
    parameter int unsigned EXP_SIZE    = EXP_SIZE_DEF,
    parameter int unsigned MANTIS_SIZE = MANTIS_SIZE_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               sign_in,
    input  logic [EXP_SIZE-1:0]                exp_in,
    input  logic [MANTIS_SIZE+2:0]             mantis_in,
    input  logic                               loss_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               sign_out,
    output logic [EXP_SIZE-1:0]                exp_out,
    output logic [MANTIS_SIZE+2:0]             mantis_out,
    output logic                               loss_out,
    output logic [$clog2(MANTIS_SIZE+3)-1:0]   shift_cnt
);

    localparam int unsigned MW = MANTIS_SIZE + 3;
    localparam int unsigned CW = $clog2(MW);

    localparam logic [EXP_SIZE-1:0] ExpOne = 1;
    localparam logic [CW-1:0]       CntOne = 1;

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic                loss_q, loss_d;
    logic [EXP_SIZE-1:0] exp_q, exp_d;
    logic [MW-1:0]       mant_q, mant_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [MW-1:0]       mant_sh;
    logic [EXP_SIZE-1:0] exp_dec;

    assign mant_sh = mant_q << 1;
    assign exp_dec = exp_q - ExpOne;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        loss_d  = loss_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    loss_d = loss_in;
                    cnt_d  = '0;
                    exp_d  = exp_in;
                    mant_d = mantis_in;
                    if (mantis_in == '0) begin
                        // A zero result is canonicalised to +/-0 with a zero exponent.
                        exp_d   = '0;
                        state_d = StDone;
                    end else if (mantis_in[MW-1] || (exp_in == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                // Entry guarantees exp_q > 0, so the decrement never wraps.
                mant_d = mant_sh;
                exp_d  = exp_dec;
                cnt_d  = cnt_q + CntOne;
                if (mant_sh[MW-1] || (exp_dec == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            loss_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            loss_q  <= loss_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign sign_out   = sign_q;
    assign loss_out   = loss_q;
    assign exp_out    = exp_q;
    assign mantis_out = mant_q;
    assign shift_cnt  = cnt_q;

endmodule

// File: tb/tb_normalizer.sv
// Self-checking bench for normalizer: directed corner cases plus randomized transactions
// checked against an arithmetic leading-zero model.
module tb_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [25:0] mantis_in;
    logic        loss_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [25:0] mantis_out;
    logic        loss_out;
    logic [4:0]  shift_cnt;

    int compared;
    int mismatched;

    normalizer #(
        .EXP_SIZE    (8),
        .MANTIS_SIZE (23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sign_in    (sign_in),
        .exp_in     (exp_in),
        .mantis_in  (mantis_in),
        .loss_in    (loss_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_out   (sign_out),
        .exp_out    (exp_out),
        .mantis_out (mantis_out),
        .loss_out   (loss_out),
        .shift_cnt  (shift_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Normalization as arithmetic: shift by min(leading zeros, exponent).
    task automatic ref_norm(input logic [7:0] e, input logic [25:0] m,
                            output logic [7:0] e_o, output logic [25:0] m_o, output int k);
        int lz;
        if (m == 26'd0) begin
            e_o = 8'd0;
            m_o = 26'd0;
            k   = 0;
        end else begin
            lz = 26;
            for (int i = 0; i < 26; i++) begin
                if (m[i]) lz = 25 - i;
            end
            k   = (lz < int'(e)) ? lz : int'(e);
            m_o = m << k;
            e_o = e - 8'(k);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge in IDLE.
    task automatic run_txn(input string tag, input logic s, input logic [7:0] e,
                           input logic [25:0] m, input logic l, input int hold);
        logic [7:0]  e_x;
        logic [25:0] m_x;
        int          k;
        int          edges;
        ref_norm(e, m, e_x, m_x, k);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        sign_in   = s;
        exp_in    = e;
        mantis_in = m;
        loss_in   = l;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        mantis_in = $urandom();
        exp_in    = $urandom();
        sign_in   = ~s;
        loss_in   = ~l;
        edges = 1;
        while (!out_valid && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".latency"}, 64'(edges), 64'(k + 1));
        check({tag, ".exp_out"}, 64'(exp_out), 64'(e_x));
        check({tag, ".mantis_out"}, 64'(mantis_out), 64'(m_x));
        check({tag, ".shift_cnt"}, 64'(shift_cnt), 64'(k));
        check({tag, ".sign_out"}, 64'(sign_out), 64'(s));
        check({tag, ".loss_out"}, 64'(loss_out), 64'(l));
        check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_result"}, {29'd0, sign_out, loss_out, exp_out, mantis_out, shift_cnt},
                  {29'd0, s, l, e_x, m_x, 5'(k)});
        end
        // Offer a new input during the handoff edge; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mantis_in = 26'h0000001;
        exp_in    = 8'd50;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".release_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".release_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [25:0] rm;
        logic [7:0]  re;
        logic        seen;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sign_in    = 1'b0;
        exp_in     = 8'd0;
        mantis_in  = 26'd0;
        loss_in    = 1'b0;

        #12;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.outputs", {31'd0, sign_out, loss_out, exp_out, mantis_out, shift_cnt},
              64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);

        run_txn("msb_set", 1'b0, 8'd100, 26'h2000000, 1'b0, 1);
        run_txn("two_shift", 1'b1, 8'd100, 26'h0800000, 1'b0, 0);
        run_txn("denormal", 1'b0, 8'd1, 26'h0000001, 1'b1, 0);
        run_txn("zero", 1'b1, 8'd50, 26'h0000000, 1'b1, 0);
        run_txn("exp_zero", 1'b0, 8'd0, 26'h0001234, 1'b0, 0);
        run_txn("stall", 1'b1, 8'd20, 26'h0040000, 1'b1, 5);
        run_txn("lz_eq_exp", 1'b0, 8'd25, 26'h0000001, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            rm = 26'($urandom()) >> $urandom_range(0, 26);
            re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            run_txn("random", 1'($urandom()), re, rm, 1'($urandom()), $urandom_range(0, 2));
        end

        // Abort a long shift sequence with an asynchronous reset.
        sign_in   = 1'b1;
        loss_in   = 1'b1;
        exp_in    = 8'd100;
        mantis_in = 26'h0000100;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.outputs", {31'd0, sign_out, loss_out, exp_out, mantis_out, shift_cnt},
              64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_output", 64'(seen), 64'd0);

        run_txn("post_abort", 1'b0, 8'd7, 26'h0100000, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 SHALL have parameter EXP_SIZE, default `EXP_SIZE from configuration.v, exponent width.
REQ-002 SHALL have parameter MANTIS_SIZE, default `MANTIS_SIZE from configuration.v, stored fraction width; MW = MANTIS_SIZE+3 is the working mantissa width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset; one clock only.
REQ-005 SHALL have port in_valid  input  1  upstream result valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a result.
REQ-007 SHALL have port sign_in  input  1  sign of the sum/difference.
REQ-008 SHALL have port exp_in  input  EXP_SIZE  exponent of the sum/difference.
REQ-009 SHALL have port mantis_in  input  MW  unnormalized mantissa; bit MW-1 is the leading-one position.
REQ-010 SHALL have port loss_in  input  1  sticky precision-loss flag from the add stage.
REQ-011 SHALL have port out_valid  output  1  normalized result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports sign_out (1), exp_out (EXP_SIZE), mantis_out (MW), loss_out (1), all outputs, normalized result.
REQ-014 SHALL have port shift_cnt  output  clog2(MW)  number of left shifts applied.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL capture all inputs on a clock edge with in_valid&&in_ready, clearing shift_cnt to 0.
REQ-017 SHALL go from IDLE to DONE on capture when mantis_in==0, mantis_in[MW-1]==1, or exp_in==0; otherwise to SHIFT.
REQ-018 SHALL, when mantis_in==0, force exp_out=0 and mantis_out=0, keeping sign_in and loss_in.
REQ-019 SHALL in SHIFT, each cycle, shift the mantissa left by 1 with zero fill, decrement exponent by 1, increment shift_cnt by 1.
REQ-020 SHALL leave SHIFT for DONE on the edge where the updated mantissa has bit MW-1 set or the updated exponent equals 0 (denormal stop); exponent never wraps below 0.
REQ-021 SHALL have latency: out_valid asserts 1 cycle after the capture edge plus 1 cycle per shift (k shifts -> k+1 cycles).
REQ-022 SHALL hold all outputs stable in DONE while out_ready=0; on out_ready=1 go to IDLE.
REQ-023 SHALL not accept a new input in the cycle the DONE->IDLE handoff happens (in_ready deasserted in DONE; no bypass).
REQ-024 SHALL pass loss_out = captured loss_in unchanged (left shift loses no bits).
REQ-025 SHALL pass sign_out = captured sign_in unchanged.

Reset
REQ-026 SHALL on rst_n=0, asynchronously, force state IDLE, out_valid=0, in_ready=1 after release, sign_out=0, exp_out=0, mantis_out=0, loss_out=0, shift_cnt=0.
REQ-027 SHALL abandon any in-flight operation when reset asserts mid-SHIFT or mid-DONE; no output is produced for it.

Structure
REQ-028 SHALL take EXP_SIZE and MANTIS_SIZE from the shared configuration.v header; FSM state encodings SHALL be defined there as shared constants.
REQ-029 SHALL be a single module with no sub-module; the one-bit shifter/decrementer is inline.

Verification (MANTIS_SIZE=23, EXP_SIZE=8, MW=26)
REQ-030 SHALL cover: mantis_in=26'h2000000, exp_in=100 -> out_valid 1 cycle after capture, exp_out=100, mantis_out=26'h2000000, shift_cnt=0.
REQ-031 SHALL cover: mantis_in=26'h0800000, exp_in=100 -> out_valid 3 cycles after capture, exp_out=98, mantis_out=26'h2000000, shift_cnt=2.
REQ-032 SHALL cover: mantis_in=26'h0000001, exp_in=1 -> exp_out=0, mantis_out=26'h0000002, shift_cnt=1 (denormal stop).
REQ-033 SHALL cover: mantis_in=0, exp_in=50, sign_in=1, loss_in=1 -> exp_out=0, mantis_out=0, sign_out=1, loss_out=1, shift_cnt=0.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-035 SHALL cover: rst_n pulsed low during SHIFT of mantis_in=26'h0000100 -> all outputs 0 immediately, IDLE after release, no out_valid.
